// File: rtl/axi_lite_adder_slave.sv
// ---------------------------------------------------------------------------
// axi_lite_adder_slave
//   AXI4-Lite register endpoint holding two operands (OPA, OPB) and exposing
//   their registered sum (RESULT) plus a STATUS word (carry + write count).
//   Window: BASE_ADDR .. BASE_ADDR+15, four 32-bit registers.
//     +0  OPA     RW, byte strobed
//     +4  OPB     RW, byte strobed
//     +8  RESULT  RO, OPA+OPB mod 2^32 (one register stage behind operands)
//     +12 STATUS  RO, [16] carry-out, [15:0] saturating operand-write count
//
// Ports
//   s_axi_aclk / s_axi_aresetn   clock, asynchronous active-low reset
//   s_axi_aw*                    write address channel
//   s_axi_w*                     write data channel (top strobe bit ignored)
//   s_axi_b*                     write response channel
//   s_axi_ar*                    read address channel
//   s_axi_r*                     read data channel
// Responses: OKAY = 0, SLVERR = 2 (out of window, misaligned, write to RO).
// ---------------------------------------------------------------------------
module axi_lite_adder_slave #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 8,
  parameter int RESP_WIDTH = 3,
  parameter int BASE_ADDR  = 0
) (
  input  logic                      s_axi_aclk,
  input  logic                      s_axi_aresetn,
  input  logic [ADDR_WIDTH-1:0]     s_axi_awaddr,
  input  logic                      s_axi_awvalid,
  output logic                      s_axi_awready,
  input  logic [DATA_WIDTH-1:0]     s_axi_wdata,
  input  logic [DATA_WIDTH/8:0]     s_axi_wstrb,
  input  logic                      s_axi_wvalid,
  output logic                      s_axi_wready,
  output logic [RESP_WIDTH-1:0]     s_axi_bresp,
  output logic                      s_axi_bvalid,
  input  logic                      s_axi_bready,
  input  logic [ADDR_WIDTH-1:0]     s_axi_araddr,
  input  logic                      s_axi_arvalid,
  output logic                      s_axi_arready,
  output logic [DATA_WIDTH-1:0]     s_axi_rdata,
  output logic [RESP_WIDTH-1:0]     s_axi_rresp,
  output logic                      s_axi_rvalid,
  input  logic                      s_axi_rready
);

  localparam int NBYTES = DATA_WIDTH / 8;
  localparam logic [ADDR_WIDTH-1:0] BASE        = ADDR_WIDTH'(BASE_ADDR);
  localparam logic [RESP_WIDTH-1:0] RESP_OKAY   = '0;
  localparam logic [RESP_WIDTH-1:0] RESP_SLVERR = RESP_WIDTH'(2);

  // Holding registers
  logic                  aw_full_q, aw_full_d;
  logic [ADDR_WIDTH-1:0] aw_addr_q, aw_addr_d;
  logic                  w_full_q,  w_full_d;
  logic [DATA_WIDTH-1:0] w_data_q,  w_data_d;
  logic [NBYTES-1:0]     w_strb_q,  w_strb_d;
  // Response state
  logic                  bvalid_q,  bvalid_d;
  logic [RESP_WIDTH-1:0] bresp_q,   bresp_d;
  logic                  rvalid_q,  rvalid_d;
  logic [RESP_WIDTH-1:0] rresp_q,   rresp_d;
  logic [DATA_WIDTH-1:0] rdata_q,   rdata_d;
  // Register file and sum pipeline
  logic [DATA_WIDTH-1:0] opa_q,     opa_d;
  logic [DATA_WIDTH-1:0] opb_q,     opb_d;
  logic [DATA_WIDTH-1:0] result_q,  result_d;
  logic                  carry_q,   carry_d;
  logic [15:0]           cnt_q,     cnt_d;

  logic                  aw_hs, w_hs, ar_hs, commit;
  logic [ADDR_WIDTH-1:0] wr_addr, wr_off, rd_off;
  logic [DATA_WIDTH-1:0] wr_data;
  logic [NBYTES-1:0]     wr_strb;
  logic                  wr_ok, rd_ok;
  logic [DATA_WIDTH-1:0] rd_val;
  logic                  unused_strb_top;

  assign unused_strb_top = s_axi_wstrb[NBYTES];

  // Readies are gated by the reset input so they drop the instant reset
  // asserts and rise in the first cycle after release.
  assign s_axi_awready = s_axi_aresetn & ~aw_full_q & ~bvalid_q;
  assign s_axi_wready  = s_axi_aresetn & ~w_full_q  & ~bvalid_q;
  assign s_axi_arready = s_axi_aresetn & ~rvalid_q;
  assign s_axi_bvalid  = bvalid_q;
  assign s_axi_bresp   = bresp_q;
  assign s_axi_rvalid  = rvalid_q;
  assign s_axi_rresp   = rresp_q;
  assign s_axi_rdata   = rdata_q;

  always_comb begin
    aw_hs  = s_axi_awvalid & s_axi_awready;
    w_hs   = s_axi_wvalid  & s_axi_wready;
    ar_hs  = s_axi_arvalid & s_axi_arready;
    // A write commits on the edge where both halves are available, whether
    // they come from the holding registers or from this edge's handshake.
    commit = (aw_full_q | aw_hs) & (w_full_q | w_hs);

    wr_addr = aw_full_q ? aw_addr_q : s_axi_awaddr;
    wr_data = w_full_q  ? w_data_q  : s_axi_wdata;
    wr_strb = w_full_q  ? w_strb_q  : s_axi_wstrb[NBYTES-1:0];

    // Offset subtraction wraps for addresses below BASE, so a single
    // "upper bits zero" test covers both window bounds.
    wr_off = wr_addr - BASE;
    wr_ok  = (wr_off[ADDR_WIDTH-1:4] == '0) && (wr_off[1:0] == 2'b00) && !wr_off[3];
    rd_off = s_axi_araddr - BASE;
    rd_ok  = (rd_off[ADDR_WIDTH-1:4] == '0) && (rd_off[1:0] == 2'b00);

    case (rd_off[3:2])
      2'd0:    rd_val = opa_q;
      2'd1:    rd_val = opb_q;
      2'd2:    rd_val = result_q;
      default: rd_val = {{(DATA_WIDTH-17){1'b0}}, carry_q, cnt_q};
    endcase

    aw_full_d = aw_full_q | aw_hs;
    aw_addr_d = aw_hs ? s_axi_awaddr : aw_addr_q;
    w_full_d  = w_full_q | w_hs;
    w_data_d  = w_hs ? s_axi_wdata : w_data_q;
    w_strb_d  = w_hs ? s_axi_wstrb[NBYTES-1:0] : w_strb_q;
    bvalid_d  = bvalid_q & ~s_axi_bready;
    bresp_d   = bresp_q;
    opa_d     = opa_q;
    opb_d     = opb_q;
    cnt_d     = cnt_q;

    if (commit) begin
      aw_full_d = 1'b0;
      w_full_d  = 1'b0;
      bvalid_d  = 1'b1;
      bresp_d   = wr_ok ? RESP_OKAY : RESP_SLVERR;
      if (wr_ok) begin
        for (int i = 0; i < NBYTES; i++) begin
          if (wr_strb[i]) begin
            if (wr_off[2]) opb_d[8*i +: 8] = wr_data[8*i +: 8];
            else           opa_d[8*i +: 8] = wr_data[8*i +: 8];
          end
        end
        if (cnt_q != 16'hFFFF) cnt_d = cnt_q + 16'd1;
      end
    end

    // Sum stage: follows the operand registers by one cycle.
    {carry_d, result_d} = {1'b0, opa_q} + {1'b0, opb_q};

    rvalid_d = rvalid_q & ~s_axi_rready;
    rresp_d  = rresp_q;
    rdata_d  = rdata_q;
    if (ar_hs) begin
      rvalid_d = 1'b1;
      rresp_d  = rd_ok ? RESP_OKAY : RESP_SLVERR;
      rdata_d  = rd_ok ? rd_val : '0;
    end
  end

  always_ff @(posedge s_axi_aclk or negedge s_axi_aresetn) begin
    if (!s_axi_aresetn) begin
      aw_full_q <= 1'b0;
      aw_addr_q <= '0;
      w_full_q  <= 1'b0;
      w_data_q  <= '0;
      w_strb_q  <= '0;
      bvalid_q  <= 1'b0;
      bresp_q   <= '0;
      rvalid_q  <= 1'b0;
      rresp_q   <= '0;
      rdata_q   <= '0;
      opa_q     <= '0;
      opb_q     <= '0;
      result_q  <= '0;
      carry_q   <= 1'b0;
      cnt_q     <= '0;
    end else begin
      aw_full_q <= aw_full_d;
      aw_addr_q <= aw_addr_d;
      w_full_q  <= w_full_d;
      w_data_q  <= w_data_d;
      w_strb_q  <= w_strb_d;
      bvalid_q  <= bvalid_d;
      bresp_q   <= bresp_d;
      rvalid_q  <= rvalid_d;
      rresp_q   <= rresp_d;
      rdata_q   <= rdata_d;
      opa_q     <= opa_d;
      opb_q     <= opb_d;
      result_q  <= result_d;
      carry_q   <= carry_d;
      cnt_q     <= cnt_d;
    end
  end

endmodule

// File: tb/tb_axi_lite_adder_slave.sv
// ---------------------------------------------------------------------------
// tb_axi_lite_adder_slave
//   Directed bench for axi_lite_adder_slave placed at base 16. A vector table
//   of single writes/reads with hand-computed results, followed by hand-driven
//   sequences for decoupled channels, same-edge read/commit and mid-write
//   reset. Inputs change on the falling edge; outputs are sampled there too.
// ---------------------------------------------------------------------------
module tb_axi_lite_adder_slave;

  localparam int B = 16;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [7:0]  awaddr = '0;
  logic        awvalid = 1'b0;
  logic        awready;
  logic [31:0] wdata = '0;
  logic [4:0]  wstrb = '0;
  logic        wvalid = 1'b0;
  logic        wready;
  logic [2:0]  bresp;
  logic        bvalid;
  logic        bready = 1'b0;
  logic [7:0]  araddr = '0;
  logic        arvalid = 1'b0;
  logic        arready;
  logic [31:0] rdata;
  logic [2:0]  rresp;
  logic        rvalid;
  logic        rready = 1'b0;

  int checks = 0;
  int errors = 0;

  axi_lite_adder_slave #(
    .DATA_WIDTH(32), .ADDR_WIDTH(8), .RESP_WIDTH(3), .BASE_ADDR(B)
  ) dut (
    .s_axi_aclk(clk),       .s_axi_aresetn(rst_n),
    .s_axi_awaddr(awaddr),  .s_axi_awvalid(awvalid), .s_axi_awready(awready),
    .s_axi_wdata(wdata),    .s_axi_wstrb(wstrb),     .s_axi_wvalid(wvalid),
    .s_axi_wready(wready),
    .s_axi_bresp(bresp),    .s_axi_bvalid(bvalid),   .s_axi_bready(bready),
    .s_axi_araddr(araddr),  .s_axi_arvalid(arvalid), .s_axi_arready(arready),
    .s_axi_rdata(rdata),    .s_axi_rresp(rresp),     .s_axi_rvalid(rvalid),
    .s_axi_rready(rready)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  task automatic do_write(input logic [7:0] a, input logic [31:0] d, input logic [4:0] s,
                          output logic [2:0] resp);
    bit aw_f, w_f, b_f, done;
    int n;
    done = 0; n = 0; resp = 3'h7;
    @(negedge clk);
    awaddr = a; awvalid = 1'b1; wdata = d; wstrb = s; wvalid = 1'b1; bready = 1'b1;
    while (!done && n < 50) begin
      aw_f = awvalid && awready;
      w_f  = wvalid && wready;
      b_f  = bvalid && bready;
      if (b_f) resp = bresp;
      @(posedge clk);
      @(negedge clk);
      if (aw_f) awvalid = 1'b0;
      if (w_f)  wvalid  = 1'b0;
      if (b_f)  begin bready = 1'b0; done = 1; end
      n++;
    end
    awvalid = 1'b0; wvalid = 1'b0; bready = 1'b0;
    chk("write_done", 32'(done), 32'd1);
  endtask

  task automatic do_read(input logic [7:0] a, output logic [31:0] d, output logic [2:0] resp);
    bit ar_f, r_f, done;
    int n;
    done = 0; n = 0; d = 'x; resp = 3'h7;
    @(negedge clk);
    araddr = a; arvalid = 1'b1; rready = 1'b1;
    while (!done && n < 50) begin
      ar_f = arvalid && arready;
      r_f  = rvalid && rready;
      if (r_f) begin d = rdata; resp = rresp; end
      @(posedge clk);
      @(negedge clk);
      if (ar_f) arvalid = 1'b0;
      if (r_f)  begin rready = 1'b0; done = 1; end
      n++;
    end
    arvalid = 1'b0; rready = 1'b0;
    chk("read_done", 32'(done), 32'd1);
  endtask

  typedef struct {
    bit          wr;
    logic [7:0]  addr;
    logic [31:0] data;
    logic [4:0]  strb;
    logic [2:0]  resp;
    logic [31:0] rdata;
  } vec_t;

  vec_t vecs[24];

  initial begin
    logic [31:0] rd;
    logic [2:0]  rsp;
    string       nm;

    // W: {1, addr, data, strb, resp, -}   R: {0, addr, -, -, resp, rdata}
    vecs[0]  = '{1, 8'(B+0),  32'h0000_0005, 5'h0F, 3'd0, 32'h0};
    vecs[1]  = '{1, 8'(B+4),  32'h0000_0007, 5'h0F, 3'd0, 32'h0};
    vecs[2]  = '{0, 8'(B+8),  32'h0,         5'h00, 3'd0, 32'h0000_000C};
    vecs[3]  = '{0, 8'(B+12), 32'h0,         5'h00, 3'd0, 32'h0000_0002};
    vecs[4]  = '{1, 8'(B+0),  32'hFFFF_FFFF, 5'h0F, 3'd0, 32'h0};
    vecs[5]  = '{1, 8'(B+4),  32'h0000_0002, 5'h0F, 3'd0, 32'h0};
    vecs[6]  = '{0, 8'(B+8),  32'h0,         5'h00, 3'd0, 32'h0000_0001};
    vecs[7]  = '{0, 8'(B+12), 32'h0,         5'h00, 3'd0, 32'h0001_0004};
    vecs[8]  = '{1, 8'(B+0),  32'h1122_3344, 5'h0F, 3'd0, 32'h0};
    vecs[9]  = '{1, 8'(B+0),  32'hAABB_CCDD, 5'h05, 3'd0, 32'h0};
    vecs[10] = '{0, 8'(B+0),  32'h0,         5'h00, 3'd0, 32'h11BB_33DD};
    vecs[11] = '{0, 8'(B+4),  32'h0,         5'h00, 3'd0, 32'h0000_0002};
    vecs[12] = '{1, 8'(B+8),  32'h0000_0123, 5'h0F, 3'd2, 32'h0};
    vecs[13] = '{1, 8'(B+12), 32'h0000_0456, 5'h0F, 3'd2, 32'h0};
    vecs[14] = '{1, 8'(B+3),  32'h0000_0789, 5'h0F, 3'd2, 32'h0};
    vecs[15] = '{1, 8'(B+16), 32'h0000_0ABC, 5'h0F, 3'd2, 32'h0};
    vecs[16] = '{0, 8'(B+16), 32'h0,         5'h00, 3'd2, 32'h0};
    vecs[17] = '{0, 8'(B+2),  32'h0,         5'h00, 3'd2, 32'h0};
    vecs[18] = '{0, 8'(0),    32'h0,         5'h00, 3'd2, 32'h0};
    vecs[19] = '{0, 8'(B+8),  32'h0,         5'h00, 3'd0, 32'h11BB_33DF};
    vecs[20] = '{0, 8'(B+12), 32'h0,         5'h00, 3'd0, 32'h0000_0006};
    vecs[21] = '{1, 8'(B+4),  32'hFFFF_FFFF, 5'h10, 3'd0, 32'h0};
    vecs[22] = '{0, 8'(B+4),  32'h0,         5'h00, 3'd0, 32'h0000_0002};
    vecs[23] = '{0, 8'(B+12), 32'h0,         5'h00, 3'd0, 32'h0000_0007};

    // Reset state
    repeat (3) @(negedge clk);
    chk("rst_awready", 32'(awready), 32'd0);
    chk("rst_wready",  32'(wready),  32'd0);
    chk("rst_arready", 32'(arready), 32'd0);
    chk("rst_bvalid",  32'(bvalid),  32'd0);
    chk("rst_rvalid",  32'(rvalid),  32'd0);
    chk("rst_bresp",   32'(bresp),   32'd0);
    chk("rst_rresp",   32'(rresp),   32'd0);
    chk("rst_rdata",   rdata,        32'd0);
    rst_n = 1'b1;
    #1;
    chk("rel_awready", 32'(awready), 32'd1);
    chk("rel_wready",  32'(wready),  32'd1);
    chk("rel_arready", 32'(arready), 32'd1);

    // Vector table
    for (int i = 0; i < 24; i++) begin
      if (vecs[i].wr) begin
        do_write(vecs[i].addr, vecs[i].data, vecs[i].strb, rsp);
        $sformat(nm, "v%0d_bresp", i);
        chk(nm, 32'(rsp), 32'(vecs[i].resp));
      end else begin
        do_read(vecs[i].addr, rd, rsp);
        $sformat(nm, "v%0d_rresp", i);
        chk(nm, 32'(rsp), 32'(vecs[i].resp));
        $sformat(nm, "v%0d_rdata", i);
        chk(nm, rd, vecs[i].rdata);
      end
    end

    // Decoupled: W three edges before AW, bready held low 4 cycles
    @(negedge clk);
    wdata = 32'h0000_0100; wstrb = 5'h0F; wvalid = 1'b1; bready = 1'b0;
    chk("dec_wready0", 32'(wready), 32'd1);
    @(negedge clk);
    wvalid = 1'b0;
    chk("dec_wready1", 32'(wready), 32'd0);
    chk("dec_awready1", 32'(awready), 32'd1);
    chk("dec_bvalid1", 32'(bvalid), 32'd0);
    @(negedge clk);
    chk("dec_bvalid2", 32'(bvalid), 32'd0);
    @(negedge clk);
    awaddr = 8'(B+4); awvalid = 1'b1;
    @(negedge clk);
    awvalid = 1'b0;
    for (int c = 0; c < 4; c++) begin
      $sformat(nm, "dec_hold%0d_bvalid", c);
      chk(nm, 32'(bvalid), 32'd1);
      $sformat(nm, "dec_hold%0d_bresp", c);
      chk(nm, 32'(bresp), 32'd0);
      $sformat(nm, "dec_hold%0d_rdys", c);
      chk(nm, 32'({awready, wready}), 32'd0);
      @(negedge clk);
    end
    bready = 1'b1;
    @(negedge clk);
    bready = 1'b0;
    chk("dec_bvalid_done", 32'(bvalid), 32'd0);
    chk("dec_rdys_back", 32'({awready, wready}), 32'd3);
    do_read(8'(B+4), rd, rsp);
    chk("dec_opb", rd, 32'h0000_0100);
    do_read(8'(B+12), rd, rsp);
    chk("dec_count", rd, 32'h0000_0008);

    // Read of RESULT on the same edge as an operand commit sees the old sum
    @(negedge clk);
    awaddr = 8'(B+0); awvalid = 1'b1; wdata = 32'h0; wstrb = 5'h0F; wvalid = 1'b1;
    araddr = 8'(B+8); arvalid = 1'b1; bready = 1'b0; rready = 1'b0;
    chk("same_rdys", 32'({awready, wready, arready}), 32'd7);
    @(negedge clk);
    awvalid = 1'b0; wvalid = 1'b0; arvalid = 1'b0;
    chk("same_rvalid", 32'(rvalid), 32'd1);
    chk("same_arready_busy", 32'(arready), 32'd0);
    chk("same_rdata_old", rdata, 32'h11BB_34DD);
    chk("same_bvalid", 32'(bvalid), 32'd1);
    rready = 1'b1; bready = 1'b1;
    @(negedge clk);
    rready = 1'b0; bready = 1'b0;
    do_read(8'(B+8), rd, rsp);
    chk("same_rdata_new", rd, 32'h0000_0100);

    // Reset between AW and W handshakes
    @(negedge clk);
    awaddr = 8'(B+0); awvalid = 1'b1;
    @(negedge clk);
    awvalid = 1'b0;
    chk("mid_awready", 32'(awready), 32'd0);
    rst_n = 1'b0;
    #1;
    chk("mid_rdys", 32'({awready, wready, arready}), 32'd0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      $sformat(nm, "mid_nob%0d", c);
      chk(nm, 32'(bvalid), 32'd0);
    end
    for (int r = 0; r < 4; r++) begin
      do_read(8'(B + 4*r), rd, rsp);
      $sformat(nm, "mid_reg%0d", r);
      chk(nm, rd, 32'd0);
    end
    do_write(8'(B+0), 32'h0000_0009, 5'h0F, rsp);
    chk("post_bresp_a", 32'(rsp), 32'd0);
    do_write(8'(B+4), 32'h0000_0001, 5'h0F, rsp);
    chk("post_bresp_b", 32'(rsp), 32'd0);
    do_read(8'(B+8), rd, rsp);
    chk("post_result", rd, 32'h0000_000A);
    do_read(8'(B+12), rd, rsp);
    chk("post_status", rd, 32'h0000_0002);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
